// File: rtl/clock_rate_pkg.sv
// ============================================================================
//  Module      : clock_rate_pkg
//  Description : Shared types and sizes for the clock rate controller slice.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package clock_rate_pkg;

   localparam int c_NUM_REQ = 4;
   localparam int c_SEL_W   = 2;
   localparam int c_IDX_W   = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_ACK  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ============================================================================
//  Module      : rr_arbiter4
//  Description : Combinational 4-way round-robin pick, searching upward from
//                rr_ptr with wrap. The pointer register lives in the parent.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter4
   import clock_rate_pkg::*;
(
   input  logic [c_NUM_REQ-1:0] req,
   input  logic [c_IDX_W-1:0]   rr_ptr,
   output logic                 grant_valid,
   output logic [c_IDX_W-1:0]   grant_idx
);

   logic [c_IDX_W-1:0] w_idx;

   // Walk from the farthest offset down so the nearest requester wins last.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      w_idx       = '0;
      for (int k = c_NUM_REQ - 1; k >= 0; k--) begin
         w_idx = rr_ptr + c_IDX_W'(k);
         if (req[w_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = w_idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/clock_rate_controller.sv
// ============================================================================
//  Module      : clock_rate_controller
//  Description : Shared toggle divider with four preset rates; round-robin
//                rate requests applied only at a full-period boundary.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module clock_rate_controller
   import clock_rate_pkg::*;
#(
   parameter logic [31:0] DIV0 = 32'd24_999_999,
   parameter logic [31:0] DIV1 = 32'd2_499_999,
   parameter logic [31:0] DIV2 = 32'd249_999,
   parameter logic [31:0] DIV3 = 32'd24_999
) (
   input  logic                      clock_in,
   input  logic                      reset_n,
   input  logic [c_NUM_REQ-1:0]      req,
   input  logic [2*c_NUM_REQ-1:0]    req_sel,
   output logic [c_NUM_REQ-1:0]      ack,
   output logic                      busy,
   output logic [c_SEL_W-1:0]        cur_sel,
   output logic                      clock_out
);

   state_t               r_state;
   state_t               w_state_next;
   logic [31:0]          r_counter;
   logic [31:0]          w_div_cur;
   logic                 r_clock_out;
   logic [c_SEL_W-1:0]   r_cur_sel;
   logic [c_SEL_W-1:0]   r_p_sel;
   logic [c_IDX_W-1:0]   r_rr_ptr;
   logic [c_IDX_W-1:0]   r_g;
   logic                 w_count_run;
   logic                 w_boundary;
   logic                 w_grant_valid;
   logic [c_IDX_W-1:0]   w_grant_idx;
   logic [c_SEL_W-1:0]   w_win_sel;
   logic [c_NUM_REQ-1:0] w_ack;
   logic                 w_busy;

   always_comb begin
      case (r_cur_sel)
         2'd0:    w_div_cur = DIV0;
         2'd1:    w_div_cur = DIV1;
         2'd2:    w_div_cur = DIV2;
         default: w_div_cur = DIV3;
      endcase
   end

   assign w_count_run = (r_counter != w_div_cur);
   // Falling edge of clock_out that closes a full period.
   assign w_boundary  = !w_count_run && r_clock_out;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_counter   <= '0;
         r_clock_out <= 1'b0;
      end else if (w_count_run) begin
         r_counter   <= r_counter + 32'd1;
      end else begin
         r_counter   <= '0;
         r_clock_out <= ~r_clock_out;
      end
   end

   rr_arbiter4 u_arb (
      .req         (req),
      .rr_ptr      (r_rr_ptr),
      .grant_valid (w_grant_valid),
      .grant_idx   (w_grant_idx)
   );

   assign w_win_sel = req_sel[{w_grant_idx, 1'b0} +: c_SEL_W];

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_cur_sel <= '0;
         r_p_sel   <= '0;
         r_rr_ptr  <= '0;
         r_g       <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_IDLE && w_grant_valid) begin
            r_g      <= w_grant_idx;
            r_p_sel  <= w_win_sel;
            r_rr_ptr <= w_grant_idx + 2'd1;
         end
         // New divide value takes effect the cycle after the boundary wrap.
         if (r_state == S_PEND && w_boundary) begin
            r_cur_sel <= r_p_sel;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ack        = '0;
      w_busy       = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (w_grant_valid) begin
               w_state_next = (w_win_sel == r_cur_sel) ? S_ACK : S_PEND;
            end
         end
         S_PEND: begin
            if (w_boundary) begin
               w_state_next = S_ACK;
            end
         end
         S_ACK: begin
            w_ack        = 4'b0001 << r_g;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign ack       = w_ack;
   assign busy      = w_busy;
   assign cur_sel   = r_cur_sel;
   assign clock_out = r_clock_out;

endmodule

`default_nettype wire

// File: tb/tb_clock_rate_controller.sv
// ============================================================================
//  Module      : tb_clock_rate_controller
//  Description : Self-checking bench; per-cycle period/arbitration model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_clock_rate_controller;

   logic       clock_in = 1'b0;
   logic       reset_n;
   logic [3:0] req      = 4'b0;
   logic [7:0] req_sel  = 8'b0;
   logic [3:0] ack;
   logic       busy;
   logic [1:0] cur_sel;
   logic       clock_out;
   logic [3:0] last_ack = 4'b0;

   int checks = 0;
   int errors = 0;

   always #5 clock_in = ~clock_in;

   clock_rate_controller #(
      .DIV0 (32'd1),
      .DIV1 (32'd3),
      .DIV2 (32'd0),
      .DIV3 (32'd7)
   ) dut (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .req       (req),
      .req_sel   (req_sel),
      .ack       (ack),
      .busy      (busy),
      .cur_sel   (cur_sel),
      .clock_out (clock_out)
   );

   wire [7:0] dutv = {clock_out, busy, cur_sel, ack};

   // Model: phase = cycles into the current output period of 2*(div+1).
   typedef struct {
      int         phase;
      logic [1:0] sel;
      logic [1:0] ptr;
      logic [1:0] gidx;
      logic [1:0] gsel;
      bit         pend;
      bit         ackc;
   } mstate_t;

   mstate_t m;

   function automatic int divof(input logic [1:0] s);
      case (s)
         2'd0:    return 1;
         2'd1:    return 3;
         2'd2:    return 0;
         default: return 7;
      endcase
   endfunction

   function automatic mstate_t model_reset();
      mstate_t n;
      n.phase = 0; n.sel = 2'd0; n.ptr = 2'd0; n.gidx = 2'd0;
      n.gsel = 2'd0; n.pend = 1'b0; n.ackc = 1'b0;
      return n;
   endfunction

   function automatic mstate_t model_next(input mstate_t s, input logic [3:0] rq,
                                          input logic [7:0] rs);
      mstate_t n;
      int      half;
      bit      bnd;
      bit      found;
      n     = s;
      half  = divof(s.sel) + 1;
      bnd   = (s.phase == 2 * half - 1);
      found = 1'b0;
      n.phase = bnd ? 0 : s.phase + 1;
      if (s.ackc) begin
         n.ackc = 1'b0;
      end else if (s.pend) begin
         if (bnd) begin
            n.sel  = s.gsel;
            n.pend = 1'b0;
            n.ackc = 1'b1;
         end
      end else if (rq != 4'b0) begin
         for (int k = 0; k < 4; k++) begin
            if (!found && rq[(int'(s.ptr) + k) % 4]) begin
               n.gidx = 2'((int'(s.ptr) + k) % 4);
               found  = 1'b1;
            end
         end
         n.gsel = rs[2 * n.gidx +: 2];
         n.ptr  = n.gidx + 2'd1;
         if (n.gsel == s.sel) n.ackc = 1'b1;
         else                 n.pend = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) m <= model_reset();
      else          m <= model_next(m, req, req_sel);
   end

   function automatic logic [7:0] exp_out();
      logic clk_e;
      clk_e = (m.phase >= divof(m.sel) + 1);
      return {clk_e, (m.pend || m.ackc), m.sel,
              m.ackc ? 4'(4'b0001 << m.gidx) : 4'b0000};
   endfunction

   // A requester drops its line at the edge where it sees its ack.
   always @(negedge clock_in) last_ack = ack;

   task automatic tick();
      @(posedge clock_in);
      #2;
      req = req & ~last_ack;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req     = 4'b0;
      req_sel = 8'b0;
      repeat (3) @(posedge clock_in);
      #2 reset_n = 1'b1;
      @(negedge clock_in);
      checks++; if (clock_out !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b want 0", clock_out); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (cur_sel !== 2'd0)   begin errors++; $display("FAIL reset_sel: got %0d want 0", cur_sel); end
      checks++; if (ack !== 4'b0)       begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
      tick();
   endtask

   task automatic test_idle();
      int first_rise = -1;
      int period = -1;
      logic prev = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clock_in);
         checks++; if (dutv !== exp_out()) begin errors++; $display("FAIL idle_model cyc %0d: dut %b model %b", c, dutv, exp_out()); end
         if (clock_out && !prev) begin
            if (first_rise < 0) first_rise = c;
            else if (period < 0) period = c - first_rise;
         end
         prev = clock_out;
         tick();
      end
      checks++; if (period !== 4) begin errors++; $display("FAIL idle_period: got %0d want 4", period); end
   endtask

   task automatic test_same_rate();
      req[2] = 1'b1;
      req_sel[5:4] = 2'd0;
      @(negedge clock_in);
      checks++; if (ack !== 4'b0) begin errors++; $display("FAIL same_early: ack %b want 0000", ack); end
      tick();
      @(negedge clock_in);
      checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL same_ack: ack %b want 0100", ack); end
      checks++; if (dutv !== exp_out()) begin errors++; $display("FAIL same_model: dut %b model %b", dutv, exp_out()); end
      tick();
      @(negedge clock_in);
      checks++; if ({busy, ack, cur_sel} !== 7'b0_0000_00) begin errors++; $display("FAIL same_after: busy/ack/sel %b want 0000000", {busy, ack, cur_sel}); end
      tick();
   endtask

   task automatic test_single_change();
      int acks = 0;
      int run = 0;
      int first_rise = -1;
      int period = -1;
      bit seen_first_edge = 1'b0;
      logic prev;
      req[1] = 1'b1;
      req_sel[3:2] = 2'd3;
      prev = clock_out;
      for (int c = 0; c < 60; c++) begin
         @(negedge clock_in);
         checks++; if (dutv !== exp_out()) begin errors++; $display("FAIL single_model cyc %0d: dut %b model %b", c, dutv, exp_out()); end
         if (ack == 4'b0010) acks++;
         if (clock_out !== prev) begin
            if (seen_first_edge) begin
               checks++; if (run != 2 && run != 8) begin errors++; $display("FAIL single_runt: run %0d want 2 or 8", run); end
            end
            seen_first_edge = 1'b1;
            run = 0;
            if (clock_out && acks > 0) begin
               if (first_rise < 0) first_rise = c;
               else if (period < 0) period = c - first_rise;
            end
         end
         run++;
         prev = clock_out;
         tick();
      end
      checks++; if (acks != 1) begin errors++; $display("FAIL single_ack: %0d pulses want 1", acks); end
      checks++; if (period !== 16) begin errors++; $display("FAIL single_period: got %0d want 16", period); end
   endtask

   task automatic test_contention();
      int order[$];
      int exp_first;
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      req     = 4'b1111;
      req_sel = {2'd0, 2'd3, 2'd2, 2'd1};
      for (int c = 0; c < 300 && order.size() < 4; c++) begin
         @(negedge clock_in);
         checks++; if (dutv !== exp_out()) begin errors++; $display("FAIL cont_model cyc %0d: dut %b model %b", c, dutv, exp_out()); end
         for (int i = 0; i < 4; i++) if (ack[i]) order.push_back(i);
         tick();
      end
      checks++; if (order.size() != 4) begin errors++; $display("FAIL cont_count: %0d acks want 4", order.size()); end
      for (int i = 0; i < order.size(); i++) begin
         checks++; if (order[i] != i) begin errors++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, order[i], i); end
      end
      order.delete();
      exp_first = (m.ptr == 2'd1) ? 1 : 0;
      req     = 4'b0011;
      req_sel = {4'b0, 2'd1, 2'd3};
      for (int c = 0; c < 200 && order.size() < 2; c++) begin
         @(negedge clock_in);
         checks++; if (dutv !== exp_out()) begin errors++; $display("FAIL cont2_model cyc %0d: dut %b model %b", c, dutv, exp_out()); end
         for (int i = 0; i < 4; i++) if (ack[i]) order.push_back(i);
         tick();
      end
      checks++; if (order.size() != 2) begin errors++; $display("FAIL cont2_count: %0d acks want 2", order.size()); end
      else begin
         checks++; if (order[0] != exp_first) begin errors++; $display("FAIL cont2_first: got %0d want %0d", order[0], exp_first); end
         checks++; if (order[1] != 1 - exp_first) begin errors++; $display("FAIL cont2_second: got %0d want %0d", order[1], 1 - exp_first); end
      end
   endtask

   task automatic test_drop_after_grant();
      bit dropped = 1'b0;
      int acks = 0;
      int first_rise = -1;
      int period = -1;
      logic prev = 1'b1;
      req[3] = 1'b1;
      req_sel[7:6] = 2'd2;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock_in);
         checks++; if (dutv !== exp_out()) begin errors++; $display("FAIL drop_model cyc %0d: dut %b model %b", c, dutv, exp_out()); end
         if (busy && ack == 4'b0 && req[3] && !dropped) begin
            req[3]  = 1'b0;
            dropped = 1'b1;
         end
         if (ack == 4'b1000) acks++;
         if (acks > 0 && clock_out && !prev) begin
            if (first_rise < 0) first_rise = c;
            else if (period < 0) period = c - first_rise;
         end
         prev = clock_out;
         tick();
      end
      checks++; if (!dropped) begin errors++; $display("FAIL drop_pend: busy never seen, got 0 want 1"); end
      checks++; if (acks != 1) begin errors++; $display("FAIL drop_ack: %0d pulses want 1", acks); end
      checks++; if (cur_sel !== 2'd2) begin errors++; $display("FAIL drop_sel: got %0d want 2", cur_sel); end
      checks++; if (period !== 2) begin errors++; $display("FAIL drop_period: got %0d want 2", period); end
   endtask

   task automatic test_reset_mid_pend();
      bit in_pend = 1'b0;
      int first_rise = -1;
      int period = -1;
      logic prev = 1'b0;
      req[0] = 1'b1;
      req_sel[1:0] = 2'd3;
      for (int c = 0; c < 20 && !in_pend; c++) begin
         @(negedge clock_in);
         checks++; if (dutv !== exp_out()) begin errors++; $display("FAIL rpend_model cyc %0d: dut %b model %b", c, dutv, exp_out()); end
         if (busy && ack == 4'b0) in_pend = 1'b1;
         else tick();
      end
      checks++; if (!in_pend) begin errors++; $display("FAIL rpend_reach: got 0 want 1"); end
      reset_n = 1'b0;
      req     = 4'b0;
      #1;
      checks++; if ({clock_out, busy, cur_sel, ack} !== 8'b0) begin errors++; $display("FAIL rpend_reset: got %b want 00000000", {clock_out, busy, cur_sel, ack}); end
      @(posedge clock_in);
      @(posedge clock_in);
      #2 reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock_in);
         checks++; if (ack !== 4'b0 || cur_sel !== 2'd0) begin errors++; $display("FAIL rpend_after cyc %0d: ack %b sel %0d want 0000 0", c, ack, cur_sel); end
         if (clock_out && !prev) begin
            if (first_rise < 0) first_rise = c;
            else if (period < 0) period = c - first_rise;
         end
         prev = clock_out;
         tick();
      end
      checks++; if (period !== 4) begin errors++; $display("FAIL rpend_period: got %0d want 4", period); end
   endtask

   task automatic test_random();
      int acks = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clock_in);
         checks++; if (dutv !== exp_out()) begin errors++; $display("FAIL rand_model cyc %0d: dut %b model %b", c, dutv, exp_out()); end
         if (ack != 4'b0) acks++;
         tick();
         for (int i = 0; i < 4; i++) begin
            if (!req[i] && !((m.pend || m.ackc) && m.gidx == 2'(i))
                && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               req_sel[2 * i +: 2] = 2'($urandom_range(0, 3));
            end
         end
         if (m.pend && req[m.gidx]) begin
            case ($urandom_range(0, 5))
               0:       req[m.gidx] = 1'b0;
               1:       req_sel[2 * m.gidx +: 2] = 2'($urandom_range(0, 3));
               default: ;
            endcase
         end
      end
      checks++; if (acks < 10) begin errors++; $display("FAIL rand_activity: %0d acks want >= 10", acks); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_same_rate();
      test_single_change();
      test_contention();
      test_drop_after_grant();
      test_reset_mid_pend();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/clock_rate_controller.md
# clock_rate_controller

Owns a programmable toggle-divider and shares it among four requesters, each asking for one of four preset output rates. A round-robin arbiter selects one request at a time. The rate change is applied only at a full-period boundary of `clock_out`, so the output never produces a runt pulse. Sits between the board-level 50 MHz clock and the counter, blinker and display logic of the project.

## Interface

Parameters:
- `DIV0`, default 24_999_999, divide value for rate code 0 (1 Hz at 50 MHz).
- `DIV1`, default 2_499_999, divide value for rate code 1 (10 Hz).
- `DIV2`, default 249_999, divide value for rate code 2 (100 Hz).
- `DIV3`, default 24_999, divide value for rate code 3 (1 kHz).

Ports:
- `clock_in`, input, 1 bit, system clock.
- `reset_n`, input, 1 bit, reset: asynchronous, active-low.
- `req`, input, 4 bits, per-requester rate-change request, level.
- `req_sel`, input, 8 bits, requested rate code. Requester i uses `req_sel[2i+1:2i]`.
- `ack`, output, 4 bits, one-cycle completion pulse per requester.
- `busy`, output, 1 bit, high whenever the FSM is not in IDLE.
- `cur_sel`, output, 2 bits, rate code currently driving the divider.
- `clock_out`, output, 1 bit, divided clock, registered.

## Operation

Divider:
- 32-bit `counter` counts from 0 to `div_cur`.
- When `counter == div_cur`: `counter` goes to 0 and `clock_out` toggles.
- Output period is 2·(`div_cur`+1) `clock_in` cycles.
- `div_cur` is always `DIV[cur_sel]`. The divider never stops during arbitration.

Boundary:
- The boundary is the cycle in which `counter == div_cur` and `clock_out == 1`, i.e. the falling edge that completes a full period.

FSM states: IDLE, PEND, ACK.
- IDLE, `req == 0`: stay in IDLE.
- IDLE, any `req` high: the round-robin winner is chosen, searching from `rr_ptr` upward with wrap.
  - Latch `g` = winner index and `p_sel` = the winner's `req_sel` field.
  - Set `rr_ptr` to `g+1` mod 4.
  - If `p_sel == cur_sel`, go to ACK; no divider change.
  - Otherwise go to PEND.
- PEND: hold until the boundary. At the boundary edge:
  - `counter` goes to 0 and `clock_out` goes to 0 (normal wrap);
  - `cur_sel` takes `p_sel`, so the new `div_cur` is used from the next cycle;
  - the FSM goes to ACK.
- ACK: `ack[g]` = 1 for exactly this cycle (Moore output), then go to IDLE. No arbitration takes place in ACK.

Handshake:
- A requester holds `req[i]` and `req_sel` stable until it samples `ack[i]`. It must deassert `req[i]` at that same edge.
- If `req[i]` drops in IDLE before being granted, nothing happens.
- If `req[i]` drops after its grant (in PEND), the latched change still completes and `ack[i]` still pulses.
- `req_sel` changes after the grant are ignored.

Boundary conditions:
- Simultaneous requests are served one per grant, in round-robin order. Losers wait; no request is lost while held.
- A same-rate request is acknowledged without waiting for a boundary.
- A request arriving in PEND or ACK is not considered until the next IDLE cycle.
- Counter wrap uses `!=` compare only; no overflow is possible because `counter ≤ div_cur`.

Reset (asynchronous, any state including mid-PEND): a pending change is discarded. All of the following take these values:
- `counter` = 0, `clock_out` = 0;
- `cur_sel` = 0, so the divider runs at `DIV0`;
- `rr_ptr` = 0, so requester 0 has highest priority;
- state = IDLE, `ack` = 0, `busy` = 0.

## Timing

- Request sampled in IDLE at edge t:
  - same-rate: `ack` is high in cycle t+1;
  - different rate: PEND from t+1, then ACK in the cycle after the boundary edge.
- Worst-case latency for a different rate: 1 + 2·(`div_cur`+1) + 1 cycles.
- First `clock_out` high after the switch occurs (`new div`+1) cycles after the boundary edge.
- Back-to-back service: at most one grant every 2 cycles (IDLE→ACK→IDLE).

## Structure

- Shared package `clock_rate_pkg` holds:
  - FSM state encodings (2 bits);
  - rate-code width (2);
  - requester count (4).
- Sub-module `rr_arbiter4` takes `req[3:0]` and `rr_ptr[1:0]` and returns `grant_valid` plus `grant_idx[1:0]`. It is purely combinational; the pointer register stays in the parent.
- The divider counter stays inline.

## Test plan

All scenarios use overrides `DIV0`=1, `DIV1`=3, `DIV2`=0, `DIV3`=7.

1. Reset and idle: release reset, no requests → `clock_out` period 4 cycles, `cur_sel`=0, `busy`=0, `ack`=0.
2. Single change: `req[1]`=1 with sel=3 → `busy` high, switch at the next boundary, `ack`=4'b0010 for one cycle, period becomes 16 cycles with no short pulse.
3. Same-rate request: `req[2]` with sel=0 in IDLE → `ack[2]` in the next cycle, period unchanged.
4. Contention: `req`=4'b1111, sels 1/2/3/0 → acks in order 0,1,2,3. Then a new `req[0]`+`req[1]` → `req[1]` is served first only if `rr_ptr` points to it; check against the pointer.
5. Drop after grant: `req[3]` sel=2 is granted, then deasserted in PEND → the switch still completes, `ack[3]` pulses, period becomes 2.
6. Reset mid-PEND: assert `reset_n`=0 during PEND → on release, `cur_sel`=0, no `ack`, `clock_out`=0, period 4.
